// File: rtl/can_bus_model.sv
// N-node CAN bus resolver: wired-OR of dominant drives, fault injection, DELAY-cycle
// propagation line, and idle/SOF/dominant/contention monitoring.
module can_bus_model #(
    parameter int N_NODES   = 4,
    parameter int DELAY     = 2,
    parameter int IDLE_BITS = 11,
    parameter int CNT_W     = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [N_NODES-1:0] tx_hi,
    input  logic [1:0]         fault_mode,
    input  logic               fault_trig,
    input  logic               clr_cnt,
    output logic               bus_hi,
    output logic               bus_lo,
    output logic               bus_idle,
    output logic               sof_pulse,
    output logic [CNT_W-1:0]   dom_cnt,
    output logic [CNT_W-1:0]   contention_cnt
);

    localparam int IDLE_W = $clog2(IDLE_BITS + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_BITS);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [DELAY-1:0]  dly_q, dly_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              bus_idle_q, bus_idle_d;
    logic              sof_q, sof_d;
    logic [CNT_W-1:0]  dom_q, dom_d;
    logic [CNT_W-1:0]  cont_q, cont_d;
    logic              raw, flip, res, multi_drive;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) return v + CNT_W'(1);
        return v;
    endfunction

    function automatic logic two_or_more(input logic [N_NODES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < N_NODES; i++) n += int'(v[i]);
        return n >= 2;
    endfunction

    assign bus_hi         = dly_q[DELAY-1];
    assign bus_lo         = ~bus_hi;
    assign bus_idle       = bus_idle_q;
    assign sof_pulse      = sof_q;
    assign dom_cnt        = dom_q;
    assign contention_cnt = cont_q;

    always_comb begin
        raw         = |tx_hi;
        flip        = (fault_mode == 2'b11) && fault_trig;
        multi_drive = two_or_more(tx_hi);
        res         = raw;
        unique case (fault_mode)
            2'b00:   res = raw;
            2'b01:   res = 1'b1;
            2'b10:   res = 1'b0;
            default: res = raw ^ flip;
        endcase

        // New sample enters stage 0; the oldest stage drives the bus.
        dly_d = (dly_q << 1) | DELAY'(res);

        if (bus_hi) idle_cnt_d = '0;
        else if (idle_cnt_q == IDLE_MAX) idle_cnt_d = IDLE_MAX;
        else idle_cnt_d = idle_cnt_q + IDLE_W'(1);

        // Dropping idle on the first dominant sample keeps SOF to a single pulse.
        bus_idle_d = (idle_cnt_q == IDLE_MAX) && !bus_hi;
        sof_d      = bus_hi && bus_idle_q;

        dom_d  = clr_cnt ? '0 : sat_inc(dom_q, bus_hi);
        cont_d = clr_cnt ? '0 : sat_inc(cont_q, multi_drive);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dly_q      <= '0;
            idle_cnt_q <= '0;
            bus_idle_q <= 1'b0;
            sof_q      <= 1'b0;
            dom_q      <= '0;
            cont_q     <= '0;
        end else begin
            dly_q      <= dly_d;
            idle_cnt_q <= idle_cnt_d;
            bus_idle_q <= bus_idle_d;
            sof_q      <= sof_d;
            dom_q      <= dom_d;
            cont_q     <= cont_d;
        end
    end

endmodule

// File: tb/tb_can_bus_model.sv
// Scoreboard bench for can_bus_model: directed scenarios plus bursty random traffic,
// checked against a queue-based behavioural model of the bus.
module tb_can_bus_model;

    localparam int N   = 4;
    localparam int D   = 2;
    localparam int IB  = 11;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [N-1:0]  tx_hi;
    logic [1:0]    fault_mode;
    logic          fault_trig;
    logic          clr_cnt;
    logic          bus_hi, bus_lo, bus_idle, sof_pulse;
    logic [CW-1:0] dom_cnt, contention_cnt;

    can_bus_model #(.N_NODES(N), .DELAY(D), .IDLE_BITS(IB), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .tx_hi(tx_hi), .fault_mode(fault_mode),
        .fault_trig(fault_trig), .clr_cnt(clr_cnt), .bus_hi(bus_hi), .bus_lo(bus_lo),
        .bus_idle(bus_idle), .sof_pulse(sof_pulse), .dom_cnt(dom_cnt),
        .contention_cnt(contention_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic bus_hi, bus_lo, idle, sof;
        logic [CW-1:0] dom, cont;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    int   cyc_n = 0;

    // Reference model state: values the DUT should show after the next edge.
    bit   m_hist[$];
    bit   m_bus, m_idle, m_sof;
    int   m_run, m_dom, m_cont;

    function automatic int ones(input logic [N-1:0] v);
        int n = 0;
        for (int i = 0; i < N; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic model_step(input bit r, input logic [N-1:0] t, input logic [1:0] m,
                              input bit tg, input bit c);
        bit res, old_bus, old_idle;
        if (!r) begin
            m_hist = {};
            for (int i = 0; i < D - 1; i++) m_hist.push_back(1'b0);
            m_bus = 0; m_idle = 0; m_sof = 0; m_run = 0; m_dom = 0; m_cont = 0;
        end else begin
            case (m)
                2'b00:   res = (t != 0);
                2'b01:   res = 1'b1;
                2'b10:   res = 1'b0;
                default: res = (t != 0) ^ tg;
            endcase
            old_bus  = m_bus;
            old_idle = m_idle;
            m_run    = old_bus ? 0 : m_run + 1;
            m_idle   = (m_run >= IB + 1);
            m_sof    = old_bus && old_idle;
            m_dom    = c ? 0 : ((m_dom + int'(old_bus) > MAX) ? MAX : m_dom + int'(old_bus));
            m_cont   = c ? 0 : ((ones(t) >= 2) ? ((m_cont + 1 > MAX) ? MAX : m_cont + 1) : m_cont);
            m_hist.push_back(res);
            m_bus    = m_hist.pop_front();
        end
    endtask

    task automatic cyc(input bit r, input logic [N-1:0] t, input logic [1:0] m,
                       input bit tg, input bit c);
        exp_t e;
        @(negedge CLK);
        RST_N = r; tx_hi = t; fault_mode = m; fault_trig = tg; clr_cnt = c;
        model_step(r, t, m, tg, c);
        e.bus_hi = m_bus; e.bus_lo = ~m_bus; e.idle = m_idle; e.sof = m_sof;
        e.dom = CW'(m_dom); e.cont = CW'(m_cont);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s cycle %0d got %0h expected %0h", n, cyc_n, got, want);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            cyc_n++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("bus_hi", 32'(bus_hi), 32'(e.bus_hi));
                chk("bus_lo", 32'(bus_lo), 32'(e.bus_lo));
                chk("bus_idle", 32'(bus_idle), 32'(e.idle));
                chk("sof_pulse", 32'(sof_pulse), 32'(e.sof));
                chk("dom_cnt", 32'(dom_cnt), 32'(e.dom));
                chk("contention_cnt", 32'(contention_cnt), 32'(e.cont));
            end
        end
    end

    logic [N-1:0] r_t;
    logic [1:0]   r_m;
    bit           r_r, r_tg, r_c, quiet;
    int           len;

    initial begin : stimulus
        RST_N = 1'b0; tx_hi = '0; fault_mode = 2'b00; fault_trig = 1'b0; clr_cnt = 1'b0;

        // Reset, then a single node going dominant
        repeat (3) cyc(0, 4'b0000, 2'b00, 0, 0);
        repeat (6) cyc(1, 4'b0000, 2'b00, 0, 0);
        repeat (3) cyc(1, 4'b0100, 2'b00, 0, 0);

        // Idle detection and a single start-of-frame
        repeat (14) cyc(1, 4'b0000, 2'b00, 0, 0);
        repeat (3)  cyc(1, 4'b0010, 2'b00, 0, 0);
        repeat (2)  cyc(1, 4'b0000, 2'b00, 0, 0);
        repeat (2)  cyc(1, 4'b0010, 2'b00, 0, 0);
        repeat (14) cyc(1, 4'b0000, 2'b00, 0, 0);

        // Arbitration with contention
        cyc(1, 4'b0000, 2'b00, 0, 1);
        repeat (5) cyc(1, 4'b1011, 2'b00, 0, 0);
        repeat (3) cyc(1, 4'b0001, 2'b00, 0, 0);
        repeat (4) cyc(1, 4'b0000, 2'b00, 0, 0);

        // Fault modes
        repeat (4) cyc(1, 4'b0000, 2'b01, 0, 0);
        repeat (4) cyc(1, 4'b1111, 2'b10, 0, 0);
        repeat (3) cyc(1, 4'b0000, 2'b00, 0, 0);
        cyc(1, 4'b0000, 2'b11, 1, 0);
        repeat (4) cyc(1, 4'b0000, 2'b11, 0, 0);
        repeat (2) cyc(1, 4'b0000, 2'b11, 1, 0);
        repeat (3) cyc(1, 4'b0000, 2'b11, 0, 0);
        cyc(1, 4'b0000, 2'b00, 1, 0);
        repeat (4) cyc(1, 4'b0000, 2'b00, 0, 0);

        // Counter saturation and clear-beats-increment
        cyc(1, 4'b0000, 2'b00, 0, 1);
        repeat (20) cyc(1, 4'b0001, 2'b00, 0, 0);
        cyc(1, 4'b0001, 2'b00, 0, 1);
        repeat (3) cyc(1, 4'b0001, 2'b00, 0, 0);
        repeat (3) cyc(1, 4'b0000, 2'b00, 0, 0);

        // Reset in the middle of traffic
        for (int i = 0; i < 8; i++) cyc(1, (i % 2 == 1) ? 4'b1000 : 4'b0000, 2'b00, 0, 0);
        cyc(0, 4'b1000, 2'b00, 0, 0);
        repeat (15) cyc(1, 4'b0000, 2'b00, 0, 0);
        repeat (2)  cyc(1, 4'b1000, 2'b00, 0, 0);
        repeat (3)  cyc(1, 4'b0000, 2'b00, 0, 0);

        // Bursty random traffic: alternating quiet and busy segments
        for (int s = 0; s < 120; s++) begin
            len   = $urandom_range(1, 20);
            quiet = ($urandom_range(0, 1) == 0);
            for (int k = 0; k < len; k++) begin
                r_r  = ($urandom_range(0, 299) != 0);
                r_t  = quiet ? '0 : N'($urandom_range(0, 15));
                r_m  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                r_tg = ($urandom_range(0, 5) == 0);
                r_c  = ($urandom_range(0, 63) == 0);
                cyc(r_r, r_t, r_m, r_tg, r_c);
            end
        end

        @(posedge CLK);
        #2;
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
